// File: rtl/ifu_fetch.sv
// Instruction fetch: one memory request per instruction, result handed to decode over valid/ready.
// Latency: 4 cycles per instruction with zero-wait memory (latch, request, response, hand-off).
// Backpressure: request and result are held stable until accepted; pc_stall holds the PC meanwhile. Optional: IFU_ALIGN_CHECK_EN.
module ifu_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_stall,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] req_pc;
    logic              kill;
    logic              misalign;

`ifdef IFU_ALIGN_CHECK_EN
    assign misalign     = (pc_addr[1:0] != 2'b00);
    assign mem_req_addr = req_pc;
`else
    assign misalign     = 1'b0;
    assign mem_req_addr = {req_pc[ADDR_W-1:2], 2'b00};
`endif

    assign mem_req_valid = (state == REQ);
    assign inst_valid    = (state == HOLD);
    assign pc_stall      = (state != IDLE) || kill;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!flush) state_nxt = misalign ? HOLD : REQ;
            REQ:  if (mem_req_ready) state_nxt = (flush || kill) ? DROP : WAIT;
            WAIT: begin
                if (mem_rsp_valid) state_nxt = flush ? IDLE : HOLD;
                else if (flush)    state_nxt = DROP;
            end
            HOLD: if (flush || inst_ready) state_nxt = IDLE;
            DROP: if (mem_rsp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_pc   <= '0;
            kill     <= 1'b0;
            inst     <= '0;
            inst_pc  <= '0;
            inst_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && !flush) begin
                req_pc <= pc_addr;
                if (misalign) begin
                    inst     <= NOP_INST;
                    inst_pc  <= pc_addr;
                    inst_err <= 1'b1;
                end
            end
            // A flush seen while the request waits must still kill it once accepted.
            if (state == REQ && !mem_req_ready && flush) kill <= 1'b1;
            else if (state != REQ || mem_req_ready)      kill <= 1'b0;
            if (state == WAIT && mem_rsp_valid && !flush) begin
                inst     <= mem_rsp_err ? NOP_INST : mem_rsp_data;
                inst_pc  <= req_pc;
                inst_err <= mem_rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; expected instructions go to a queue, a negedge monitor checks hand-offs.
module tb_ifu_fetch;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_addr;
    logic        pc_stall;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;

    int   checks = 0;
    int   failures = 0;
    int   hs_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .pc_stall(pc_stall), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .inst_err(inst_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            exp_t e;
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_inst got inst=%h pc=%h err=%b exp=none", inst, inst_pc, inst_err);
            end else begin
                e = exp_q.pop_front();
                if (inst !== e.inst || inst_pc !== e.pc || inst_err !== e.err) begin
                    failures++;
                    $display("FAIL inst_out got inst=%h pc=%h err=%b exp inst=%h pc=%h err=%b",
                             inst, inst_pc, inst_err, e.inst, e.pc, e.err);
                end
            end
        end
    end

    // Zero-wait fetch from IDLE; returns in IDLE four edges later.
    task automatic fetch_zw(input logic [31:0] a, input logic [31:0] d, input logic e);
        logic [31:0] aa;
        aa = {a[31:2], 2'b00};
        flush = 1'b0; pc_addr = a; mem_req_ready = 1'b1; inst_ready = 1'b1;
        step();
        chk("zw_req_valid", 64'(mem_req_valid), 64'd1);
        chk("zw_req_addr", 64'(mem_req_addr), 64'(aa));
        chk("zw_pc_stall", 64'(pc_stall), 64'd1);
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = d; mem_rsp_err = e;
        exp_q.push_back('{inst: (e ? 32'h00000013 : d), pc: a, err: e});
        step();
        mem_rsp_valid = 1'b0;
        chk("zw_inst_valid", 64'(inst_valid), 64'd1);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        rst_n = 1'b0; flush = 1'b1; pc_addr = 32'h0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; mem_rsp_err = 1'b0; inst_ready = 1'b0;
        step(); step();
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("rst_inst_err", 64'(inst_err), 64'd0);
        chk("rst_pc_stall", 64'(pc_stall), 64'd0);
        rst_n = 1'b1;
        step();
        chk("idle_flush_hold", 64'(mem_req_valid), 64'd0);

        // Zero-wait, then three back-to-back fetches in 12 cycles
        fetch_zw(32'h80000000, 32'h00100093, 1'b0);
        h0 = hs_cnt;
        fetch_zw(32'h80000004, 32'h00200113, 1'b0);
        fetch_zw(32'h80000008, 32'h00300193, 1'b0);
        fetch_zw(32'h8000000C, 32'h00400213, 1'b0);
        chk("three_fetch_12cyc", 64'(hs_cnt - h0), 64'd3);
        flush = 1'b1;
        step();

        // Backpressure on both ports
        flush = 1'b0; pc_addr = 32'h80000010; mem_req_ready = 1'b0; inst_ready = 1'b0;
        step();
        pc_addr = 32'h80000014;
        for (int i = 0; i < 3; i++) begin
            chk("bp_req_valid", 64'(mem_req_valid), 64'd1);
            chk("bp_req_addr", 64'(mem_req_addr), 64'h80000010);
            chk("bp_stall_req", 64'(pc_stall), 64'd1);
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("bp_stall_wait", 64'(pc_stall), 64'd1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00A00113; mem_rsp_err = 1'b0;
        exp_q.push_back('{inst: 32'h00A00113, pc: 32'h80000010, err: 1'b0});
        step();
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_hold_valid", 64'(inst_valid), 64'd1);
            chk("bp_hold_inst", 64'(inst), 64'h00A00113);
            chk("bp_hold_pc", 64'(inst_pc), 64'h80000010);
            chk("bp_stall_hold", 64'(pc_stall), 64'd1);
            step();
        end
        inst_ready = 1'b1;
        step();
        flush = 1'b1;
        chk("bp_done_stall", 64'(pc_stall), 64'd0);
        chk("bp_done_valid", 64'(inst_valid), 64'd0);
        step();

        // Flush in WAIT, late response dropped, refetch from new PC
        flush = 1'b0; pc_addr = 32'h80000020; mem_req_ready = 1'b1;
        step(); step();
        flush = 1'b1;
        step();
        flush = 1'b0; pc_addr = 32'h80000100;
        chk("drop_stall", 64'(pc_stall), 64'd1);
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
        step();
        mem_rsp_valid = 1'b0;
        chk("drop_no_valid", 64'(inst_valid), 64'd0);
        chk("drop_idle", 64'(pc_stall), 64'd0);
        step();
        chk("refetch_addr", 64'(mem_req_addr), 64'h80000100);
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00200193;
        exp_q.push_back('{inst: 32'h00200193, pc: 32'h80000100, err: 1'b0});
        step();
        mem_rsp_valid = 1'b0;
        step();
        flush = 1'b1;
        step();

        // Flush together with response in WAIT
        flush = 1'b0; pc_addr = 32'h80000030;
        step(); step();
        flush = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D;
        step();
        mem_rsp_valid = 1'b0;
        chk("simul_idle", 64'(pc_stall), 64'd0);
        chk("simul_no_valid", 64'(inst_valid), 64'd0);
        chk("simul_no_req", 64'(mem_req_valid), 64'd0);
        step();
        chk("simul_no_valid2", 64'(inst_valid), 64'd0);

        // Flush while the request is not yet accepted (sticky kill)
        flush = 1'b0; pc_addr = 32'h80000050; mem_req_ready = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; pc_addr = 32'h80000060;
        chk("kill_req_addr", 64'(mem_req_addr), 64'h80000050);
        chk("kill_stall", 64'(pc_stall), 64'd1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; flush = 1'b1;
        chk("kill_drop_noreq", 64'(mem_req_valid), 64'd0);
        chk("kill_drop_stall", 64'(pc_stall), 64'd1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BADC0DE;
        step();
        mem_rsp_valid = 1'b0;
        chk("kill_idle", 64'(pc_stall), 64'd0);
        chk("kill_no_valid", 64'(inst_valid), 64'd0);

        // Bus error
        fetch_zw(32'h80000040, 32'h12345678, 1'b1);
        flush = 1'b1;
        step();

        // Misaligned fetch address
`ifdef IFU_ALIGN_CHECK_EN
        flush = 1'b0; pc_addr = 32'h80000002; inst_ready = 1'b1;
        exp_q.push_back('{inst: 32'h00000013, pc: 32'h80000002, err: 1'b1});
        step();
        chk("mis_no_req", 64'(mem_req_valid), 64'd0);
        chk("mis_valid", 64'(inst_valid), 64'd1);
        flush = 1'b1;
        step();
`else
        fetch_zw(32'h80000002, 32'h00300213, 1'b0);
        flush = 1'b1;
        step();
`endif

        // Reset mid-fetch
        flush = 1'b0; pc_addr = 32'h80000070; mem_req_ready = 1'b1;
        step(); step();
        rst_n = 1'b0; flush = 1'b1;
        #1;
        chk("rstmid_stall", 64'(pc_stall), 64'd0);
        chk("rstmid_req", 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55555555;
        step();
        rst_n = 1'b1; mem_rsp_valid = 1'b0;
        step();
        chk("rstmid_no_valid", 64'(inst_valid), 64'd0);

        step(); step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
